// File: rtl/trk_epoch_sched_if.sv
// Interface for the tracking-loop epoch scheduler.
// The master side (the tracking channel) drives enable, the epoch-start pulse
// and the overrun clear. The slave side (the scheduler) returns the strobes,
// bandwidth select, epoch count and status.
interface trk_epoch_sched_if;
    logic        rx_trk_en;
    logic        rx_prn_sop;
    logic        rx_ovr_clr;
    logic        tx_disc_latch;
    logic        tx_lpf_upd;
    logic        tx_bw_sel;
    logic [31:0] tx_epoch_cnt;
    logic        tx_ovr;
    logic        tx_busy;

    modport master (
        output rx_trk_en,
        output rx_prn_sop,
        output rx_ovr_clr,
        input  tx_disc_latch,
        input  tx_lpf_upd,
        input  tx_bw_sel,
        input  tx_epoch_cnt,
        input  tx_ovr,
        input  tx_busy
    );

    modport slave (
        input  rx_trk_en,
        input  rx_prn_sop,
        input  rx_ovr_clr,
        output tx_disc_latch,
        output tx_lpf_upd,
        output tx_bw_sel,
        output tx_epoch_cnt,
        output tx_ovr,
        output tx_busy
    );
endinterface

// File: rtl/trk_epoch_sched.sv
// Per-channel epoch scheduler for the B1 tracking loop.
// Each epoch-start pulse dumps the correlators. The scheduler waits out the
// discriminator latency, strobes the discriminator capture registers, then
// strobes the loop-filter update. The first partial epoch after enable is
// discarded, bandwidth switches from pull-in to track after a programmed
// number of updates, and epoch overruns are flagged.
module trk_epoch_sched #(
    parameter int unsigned DISC_LAT    = 19,
    parameter int unsigned UPD_GAP     = 1,
    parameter int unsigned PULL_EPOCHS = 200,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             rx_clk,
    input  logic             rx_rst,
    trk_epoch_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_SETTLE,
        S_LATCH,
        S_UPDATE
    } state_t;

    // Counter value seen on the edge that must raise each strobe; the counter
    // is 1 on the edge after the sop, so it equals the edge offset from the sop.
    localparam logic [CNT_W-1:0] LATCH_AT = CNT_W'(DISC_LAT);
    localparam logic [CNT_W-1:0] UPD_AT   = CNT_W'(DISC_LAT + UPD_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             latch_q, latch_d;
    logic             upd_q, upd_d;
    logic             bw_q, bw_d;
    logic [31:0]      epoch_q, epoch_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;
    logic             ovr_set;

    // Next-state, strobe and status computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_d = 1'b0;
        upd_d   = 1'b0;
        bw_d    = bw_q;
        epoch_d = epoch_q;
        ovr_set = 1'b0;

        if (!bus.rx_trk_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bw_d    = 1'b0;
        end else begin
            // Track bandwidth takes effect the edge after the count reaches the
            // pull-in budget and then sticks until the channel is disabled.
            if (epoch_q >= PULL_EPOCHS) begin
                bw_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                    epoch_d = '0;
                    bw_d    = 1'b0;
                end
                S_ARM: begin
                    if (bus.rx_prn_sop) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rx_prn_sop) begin
                        state_d = S_SETTLE;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_SETTLE: begin
                    if (bus.rx_prn_sop) begin
                        // Overrun: the latch due on this edge (if any) is dropped.
                        ovr_set = 1'b1;
                        state_d = S_SETTLE;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == LATCH_AT) begin
                        latch_d = 1'b1;
                        state_d = S_LATCH;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_LATCH, S_UPDATE: begin
                    // A sop on the update edge is not an overrun: the update
                    // stands and the new epoch starts settling immediately.
                    if (cnt_q == UPD_AT) begin
                        upd_d = 1'b1;
                        if (epoch_q != '1) begin
                            epoch_d = epoch_q + 32'd1;
                        end
                        if (bus.rx_prn_sop) begin
                            state_d = S_SETTLE;
                            cnt_d   = CNT_ONE;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end
                    end else if (bus.rx_prn_sop) begin
                        ovr_set = 1'b1;
                        state_d = S_SETTLE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = S_UPDATE;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A new overrun beats a simultaneous clear.
        ovr_d  = ovr_set | (ovr_q & ~bus.rx_ovr_clr);
        busy_d = (state_d == S_SETTLE) || (state_d == S_LATCH) || (state_d == S_UPDATE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            upd_q   <= 1'b0;
            bw_q    <= 1'b0;
            epoch_q <= '0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            upd_q   <= upd_d;
            bw_q    <= bw_d;
            epoch_q <= epoch_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx_disc_latch = latch_q;
    assign bus.tx_lpf_upd    = upd_q;
    assign bus.tx_bw_sel     = bw_q;
    assign bus.tx_epoch_cnt  = epoch_q;
    assign bus.tx_ovr        = ovr_q;
    assign bus.tx_busy       = busy_q;

endmodule
